reg_mem_fifo_ctrl: RTL and testbench

//  Upstream controller for a reg_mem instance: turns the single-port register memory into a FIFO.
//  - Producer side: valid/ready push. Consumer side: valid/ready pop.
//  - Drives reg_mem addr/data_in/wen each cycle and consumes its data_out.
//  - A one-word output register decouples the consumer. Total capacity is DEPTH+1 words.

---
 rtl/reg_mem_fifo_ctrl_if.sv | 21 ++
 rtl/reg_mem_fifo_ctrl.sv | 89 ++++++++
 tb/tb_reg_mem_fifo_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_mem_fifo_ctrl_if.sv
// Producer/consumer valid-ready handshake bundle for reg_mem_fifo_ctrl.
interface reg_mem_fifo_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/reg_mem_fifo_ctrl.sv
// FIFO controller wrapping a single-port reg_mem plus a one-word output register.
// Optional stall counter port enabled by defining REG_MEM_FIFO_STALL_CNT_EN.
module reg_mem_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  reg_mem_fifo_ctrl_if.slave    bus,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
`ifdef REG_MEM_FIFO_STALL_CNT_EN
  output logic [15:0]           stall_cnt,
`endif
  output logic [ADDR_BITS:0]    count
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0]   MCNT_FULL = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   MCNT_ONE  = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE   = ADDR_BITS'(1);

  logic [ADDR_BITS-1:0]  wr_ptr;
  logic [ADDR_BITS-1:0]  rd_ptr;
  logic [ADDR_BITS:0]    mcnt;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  logic load, rd_go, in_ready_c, acc, byp_go, wr_go;

  // A refill read of the output register always wins the single memory port.
  always_comb begin
    load       = !out_valid_q || bus.out_ready;
    rd_go      = load && (mcnt != '0);
    in_ready_c = rst_n && !rd_go && (mcnt != MCNT_FULL);
    acc        = bus.in_valid && in_ready_c;
    byp_go     = acc && load && (mcnt == '0);
    wr_go      = acc && !byp_go;
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign mem_addr      = rd_go ? rd_ptr : wr_ptr;
  assign mem_data_in   = bus.in_data;
  assign mem_wen       = wr_go;
  assign count         = mcnt + (ADDR_BITS+1)'(out_valid_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mcnt        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (rd_go) begin
        out_data_q  <= mem_data_out;
        out_valid_q <= 1'b1;
        rd_ptr      <= rd_ptr + PTR_ONE;
      end else if (byp_go) begin
        out_data_q  <= bus.in_data;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (wr_go)
        wr_ptr <= wr_ptr + PTR_ONE;

      if (wr_go)
        mcnt <= mcnt + MCNT_ONE;
      else if (rd_go)
        mcnt <= mcnt - MCNT_ONE;
    end
  end

`ifdef REG_MEM_FIFO_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (bus.in_valid && !in_ready_c && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_reg_mem_fifo_ctrl.sv
// Scoreboard bench for reg_mem_fifo_ctrl with a behavioural reg_mem model.
module tb_reg_mem_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] mem_addr;
  logic [7:0] mem_data_in;
  logic       mem_wen;
  logic [7:0] mem_data_out;
  logic [5:0] count;
`ifdef REG_MEM_FIFO_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mem [32];

  reg_mem_fifo_ctrl_if #(.DATA_WIDTH(8)) bus ();

  reg_mem_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_BITS(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .mem_addr    (mem_addr),
    .mem_data_in (mem_data_in),
    .mem_wen     (mem_wen),
    .mem_data_out(mem_data_out),
`ifdef REG_MEM_FIFO_STALL_CNT_EN
    .stall_cnt   (stall_cnt),
`endif
    .count       (count)
  );

  always #5 clk = ~clk;

  // reg_mem: synchronous write, combinational read
  always @(posedge clk) if (mem_wen) mem[mem_addr] <= mem_data_in;
  assign mem_data_out = mem[mem_addr];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next posedge when valid & ready at negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got %0d expected none", bus.out_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin
            errors++;
            $display("FAIL pop_data: got %0d expected %0d", bus.out_data, e);
          end
        end
      end
    end
  end

  task automatic push(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(d);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    check("push_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain_wait(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h11;
    bus.out_ready = 1'b0;

    // 1. reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_count", int'(count), 0);
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_mem_wen", int'(mem_wen), 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst_n = 1'b1;

    // 2. bypass
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hA5;
    @(negedge clk);
    check("byp_in_ready", int'(bus.in_ready), 1);
    check("byp_mem_wen", int'(mem_wen), 0);
    exp_q.push_back(8'hA5);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("byp_out_valid", int'(bus.out_valid), 1);
    check("byp_out_data", int'(bus.out_data), 8'hA5);
    @(posedge clk); #1;
    check("byp_empty_valid", int'(bus.out_valid), 0);
    check("byp_empty_count", int'(count), 0);

    // 3. fill to DEPTH+1
    bus.out_ready = 1'b0;
    for (int i = 0; i <= 32; i++) push(8'(i));
    check("fill_count", int'(count), 33);
    check("fill_out_data", int'(bus.out_data), 0);
    for (int i = 0; i < 32; i++) check("fill_mem", int'(mem[i]), i + 1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd33;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_in_ready", int'(bus.in_ready), 0);
      @(posedge clk); #1;
    end
`ifdef REG_MEM_FIFO_STALL_CNT_EN
    check("stall_cnt", int'(stall_cnt), 3);
`endif
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("full_in_ready_oready", int'(bus.in_ready), 0);
    bus.in_valid = 1'b0;

    // 4. drain, one word per cycle (already at the first drain negedge)
    @(posedge clk); #1;
    repeat (32) @(posedge clk);
    #1;
    check("drain_q_empty", exp_q.size(), 0);
    check("drain_out_valid", int'(bus.out_valid), 0);
    check("drain_count", int'(count), 0);

    // 5. wrap with 3 resident words
    bus.out_ready = 1'b0;
    push(8'd100);
    push(8'd101);
    push(8'd102);
    check("wrap_resident", int'(count), 3);
    for (int i = 0; i < 40; i++) begin
      push(8'(110 + i));
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
    end
    check("wrap_count", int'(count), 3);
    bus.out_ready = 1'b1;
    drain_wait("wrap_drain");
    check("wrap_end_count", int'(count), 0);

    // 6. mid-operation reset
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(200 + i));
    check("mid_count_pre", int'(count), 5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    check("mid_count", int'(count), 0);
    check("mid_out_valid", int'(bus.out_valid), 0);
    bus.out_ready = 1'b1;
    push(8'h3C);
    check("mid_first_data", int'(bus.out_data), 8'h3C);
    drain_wait("mid_drain");
    check("mid_end_count", int'(count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
